wb_cmd_master: RTL and testbench

//  Single-outstanding Wishbone B4 classic initiator. It drives the user-project

---
 rtl/wb_cmd_master.sv | 173 +++++++++++++++++
 tb/tb_wb_cmd_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Single-outstanding Wishbone B4 classic initiator driven by a command stream
//
// Purpose: turns one accepted command (valid/ready) into exactly one Wishbone
// classic bus cycle and one response beat (valid/ready).
// Optional feature macro: WB_MASTER_TIMEOUT_EN (ack wait limit of TIMEOUT_CYCLES).
//
// Ports:
//   wb_clk_i, wb_rst_i                      clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o                 command handshake
//   cmd_we_i/cmd_adr_i/cmd_dat_i/cmd_sel_i  command fields (sampled only at accept)
//   rsp_valid_o/rsp_ready_i                 response handshake
//   rsp_dat_o/rsp_err_o                     read data (0 on write/error), error flag
//   busy_o                                  high when not idle
//   wbm_*                                   Wishbone initiator signals

module wb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_W-1:0]     cmd_adr_i,
    input  logic [DATA_W-1:0]     cmd_dat_i,
    input  logic [DATA_W/8-1:0]   cmd_sel_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [DATA_W/8-1:0]   wbm_sel_o,
    output logic [ADDR_W-1:0]     wbm_adr_o,
    output logic [DATA_W-1:0]     wbm_dat_o,
    input  logic [DATA_W-1:0]     wbm_dat_i,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic                rsp_err_q, rsp_err_d;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CNT_W = 16;
    // wait_q counts completed no-ack BUS cycles; the timeout fires in the
    // cycle that would complete the TIMEOUT_CYCLES-th wait, so cyc stays
    // high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]    wait_q, wait_d;
`endif

    assign cmd_ready_o = (state_q == S_IDLE) && !wb_rst_i;
    assign busy_o      = (state_q != S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
`ifdef WB_MASTER_TIMEOUT_EN
        wait_d      = wait_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    state_d = S_BUS;
                    cyc_d   = 1'b1;
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    // Word-aligned bus address: low two byte-offset bits forced to 0.
                    adr_d   = cmd_adr_i & ~ADDR_W'(3);
                    dat_d   = cmd_dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            S_BUS: begin
                if (wbm_ack_i || wbm_err_i) begin
                    // ERR takes precedence over a simultaneous ACK.
                    state_d     = S_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = wbm_err_i;
                    rsp_dat_d   = (!we_q && !wbm_err_i) ? wbm_dat_i : '0;
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    state_d     = S_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
`ifdef WB_MASTER_TIMEOUT_EN
            wait_q      <= wait_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - Self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        ack, err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
        .rsp_err_o(rsp_err), .busy_o(busy),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i),
        .wbm_ack_i(ack), .wbm_err_i(err)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          delay;
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        int          hold;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a terminated cycle reports error if ERR was seen; data only for clean reads.
    function automatic void model(input vec_t v, output logic [31:0] e_adr,
                                  output logic [31:0] e_dat, output logic e_err);
        e_adr = (v.adr / 4) * 4;
        e_err = v.err;
        e_dat = (v.err || v.we) ? 32'h0 : v.rdata;
    endfunction

    // Starts and ends just after a falling edge with the DUT idle.
    task automatic run_txn(input vec_t v);
        chk("idle_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = ~v.we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
        for (int k = 0; k <= v.delay; k++) begin
            chk("bus_cyc", 32'(cyc), 1);
            chk("bus_stb", 32'(stb), 1);
            chk("bus_we", 32'(we), 32'(v.we));
            chk("bus_sel", 32'(sel), 32'(v.sel));
            chk("bus_adr", adr, v.exp_adr);
            chk("bus_dat", dat_o, v.dat);
            chk("bus_ready", 32'(cmd_ready), 0);
            chk("bus_busy", 32'(busy), 1);
            chk("bus_rspv", 32'(rsp_valid), 0);
            dat_i = $urandom;
            if (k == v.delay) begin
                ack = v.ack; err = v.err; dat_i = v.rdata;
            end
            @(negedge clk);
        end
        ack = 1'b0; err = 1'b0;
        chk("term_cyc", 32'(cyc), 0);
        chk("term_stb", 32'(stb), 0);
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("rsp_dat", rsp_dat, v.exp_dat);
        chk("rsp_ready_hold", 32'(cmd_ready), 0);
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1;
            ack = 1'($urandom_range(0, 1));
            err = 1'($urandom_range(0, 1));
            dat_i = $urandom;
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_err", 32'(rsp_err), 32'(v.exp_err));
            chk("hold_dat", rsp_dat, v.exp_dat);
            chk("hold_cyc", 32'(cyc), 0);
            chk("hold_ready", 32'(cmd_ready), 0);
        end
        cmd_valid = 1'b0; ack = 1'b0; err = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_valid", 32'(rsp_valid), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_ready", 32'(cmd_ready), 1);
        chk("done_cyc", 32'(cyc), 0);
    endtask

    task automatic start_read(input logic [31:0] a);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = a; cmd_dat = 32'h0; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        vec_t v;
        int   n;

        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; dat_i = '0; ack = 1'b0; err = 1'b0;

        //            we    adr           dat           sel   dly ack   err   rdata         hold exp_adr       exp_dat       exp_err
        tbl[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 2, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 32'h3000_0004, 32'h0,         1'b0};
        tbl[1] = '{1'b0, 32'h3000_0007, 32'h0,         4'hF, 0, 1'b1, 1'b0, 32'h1234_5678, 1, 32'h3000_0004, 32'h1234_5678, 1'b0};
        tbl[2] = '{1'b0, 32'h1000_0010, 32'h1111_2222, 4'h3, 1, 1'b1, 1'b0, 32'hCAFE_F00D, 5, 32'h1000_0010, 32'hCAFE_F00D, 1'b0};
        tbl[3] = '{1'b0, 32'h2000_0002, 32'h0,         4'hF, 1, 1'b1, 1'b1, 32'hFFFF_FFFF, 0, 32'h2000_0000, 32'h0,         1'b1};
        tbl[4] = '{1'b1, 32'h0000_00FF, 32'h0BAD_CAFE, 4'h8, 3, 1'b0, 1'b1, 32'h7777_7777, 2, 32'h0000_00FC, 32'h0,         1'b1};
        tbl[5] = '{1'b0, 32'h4000_0008, 32'h0,         4'hF, 0, 1'b0, 1'b1, 32'h0000_55AA, 0, 32'h4000_0008, 32'h0,         1'b1};

        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_cyc", 32'(cyc), 0);
        chk("rst_stb", 32'(stb), 0);
        chk("rst_adr", adr, 0);
        chk("rst_rspv", 32'(rsp_valid), 0);
        chk("rst_rspd", rsp_dat, 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Stray ACK/ERR while idle must not start anything.
        ack = 1'b1; err = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ack = 1'b0; err = 1'b0;
        chk("idle_ack_busy", 32'(busy), 0);
        chk("idle_ack_rspv", 32'(rsp_valid), 0);
        chk("idle_ack_cyc", 32'(cyc), 0);

        for (int i = 0; i < 40; i++) begin
            int r;
            v.we = 1'($urandom_range(0, 1));
            v.adr = $urandom; v.dat = $urandom; v.sel = 4'($urandom);
            v.delay = $urandom_range(0, 5);
            r = $urandom_range(0, 3);
            v.ack = (r != 1); v.err = (r <= 1);
            v.rdata = $urandom;
            v.hold = $urandom_range(0, 3);
            model(v, v.exp_adr, v.exp_dat, v.exp_err);
            run_txn(v);
        end

        // Slave that never answers.
        start_read(32'h5000_0000);
`ifdef WB_MASTER_TIMEOUT_EN
        n = 0;
        while (cyc && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_len", 32'(n), 16);
        chk("timeout_valid", 32'(rsp_valid), 1);
        chk("timeout_err", 32'(rsp_err), 1);
        chk("timeout_dat", rsp_dat, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("timeout_done", 32'(cmd_ready), 1);
`else
        n = 0;
        repeat (1000) @(negedge clk);
        chk("stuck_cyc", 32'(cyc), 1);
        chk("stuck_rspv", 32'(rsp_valid), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("stuck_recover", 32'(cmd_ready), 1);
`endif

        // One-cycle reset mid-BUS, with an ACK arriving on the same edge.
        start_read(32'h6000_0010);
        @(negedge clk);
        chk("prerst_cyc", 32'(cyc), 1);
        rst = 1'b1; ack = 1'b1; dat_i = 32'h1357_9BDF;
        @(negedge clk);
        chk("midrst_cyc", 32'(cyc), 0);
        chk("midrst_stb", 32'(stb), 0);
        chk("midrst_adr", adr, 0);
        chk("midrst_rspv", 32'(rsp_valid), 0);
        chk("midrst_ready", 32'(cmd_ready), 0);
        rst = 1'b0; ack = 1'b0;
        @(negedge clk);
        chk("postrst_ready", 32'(cmd_ready), 1);
        chk("postrst_rspv", 32'(rsp_valid), 0);
        chk("postrst_busy", 32'(busy), 0);
        @(negedge clk);
        chk("postrst_rspv2", 32'(rsp_valid), 0);

        // Normal operation after the reset.
        v = '{1'b0, 32'h7000_0003, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h0246_8ACE, 0, 32'h7000_0000, 32'h0246_8ACE, 1'b0};
        run_txn(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
